// File: rtl/host_loader_pkg.sv
// host_loader_pkg: constants and state types shared by the host loader files.
//   HS_BOOT / HS_SLD  : handshake bytes the device sends before each upload
//   TERM_WORD         : terminator word found in image and SLD streams
//   RESULT_BASE_WORD  : device word address where result bytes originate
package host_loader_pkg;

   localparam logic [7:0]  HS_BOOT          = 8'h99;
   localparam logic [7:0]  HS_SLD           = 8'haa;
   localparam logic [31:0] TERM_WORD        = 32'hffff_ffff;
   localparam int          RESULT_BASE_WORD = 4096;

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_99, S_SEND_LEN, S_IMG_FETCH, S_IMG_SEND,
      S_WAIT_AA, S_SLD_FETCH, S_SLD_SEND, S_RECV, S_DONE, S_ERR
   } state_t;

   typedef enum logic [1:0] {
      BT_IDLE, BT_ARM, BT_RUN
   } btx_state_t;

endpackage

// File: rtl/host_byte_tx.sv
// host_byte_tx: one-byte send handshake in front of uart_tx.
//   byte_val, go : byte to send and a request pulse (taken only when ready)
//   ready        : high when idle; drops the cycle after go is taken and
//                  rises again once uart_tx has finished the byte
//   sdata, tx_start, tx_busy : uart_tx side
module host_byte_tx
   import host_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] byte_val,
   input  logic       go,
   output logic       ready,
   output logic [7:0] sdata,
   output logic       tx_start,
   input  logic       tx_busy
);

   btx_state_t st;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         st       <= BT_IDLE;
         ready    <= 1'b1;
         sdata    <= 8'd0;
         tx_start <= 1'b0;
      end else begin
         case (st)
            BT_IDLE: if (go) begin
               sdata    <= byte_val;
               tx_start <= 1'b1;
               ready    <= 1'b0;
               st       <= BT_ARM;
            end
            // Hold the request until uart_tx acknowledges with busy.
            BT_ARM: if (tx_busy) begin
               tx_start <= 1'b0;
               st       <= BT_RUN;
            end
            BT_RUN: if (!tx_busy) begin
               ready <= 1'b1;
               st    <= BT_IDLE;
            end
            default: st <= BT_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling.
//   clk, rstn : clock, synchronous active-low reset
//   rxd       : serial input (asynchronous, double-registered here)
//   rdata     : last good byte, updated together with rx_ready
//   rx_ready  : one-cycle pulse per byte with a valid stop bit
//   ferr      : one-cycle pulse when the stop bit reads low
module uart_rx #(
   parameter int CLK_PER_HALF_BIT = 200
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   output logic [7:0] rdata,
   output logic       rx_ready,
   output logic       ferr
);

   localparam logic [15:0] HALF_LAST = 16'(CLK_PER_HALF_BIT - 1);
   localparam logic [15:0] BIT_LAST  = 16'(2 * CLK_PER_HALF_BIT - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

   rstate_t     st;
   logic [1:0]  sync;
   logic [15:0] cnt;
   logic [2:0]  bcnt;
   logic [7:0]  sh;
   logic        rs;

   assign rs = sync[1];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         st       <= R_IDLE;
         sync     <= 2'b11;
         cnt      <= 16'd0;
         bcnt     <= 3'd0;
         sh       <= 8'd0;
         rdata    <= 8'd0;
         rx_ready <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         sync     <= {sync[0], rxd};
         rx_ready <= 1'b0;
         ferr     <= 1'b0;
         case (st)
            R_IDLE: begin
               cnt <= 16'd0;
               if (!rs) st <= R_START;
            end
            // Re-check at the middle of the start bit to reject glitches.
            R_START: begin
               if (cnt == HALF_LAST) begin
                  cnt  <= 16'd0;
                  bcnt <= 3'd0;
                  st   <= rs ? R_IDLE : R_DATA;
               end else cnt <= cnt + 16'd1;
            end
            R_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt  <= 16'd0;
                  sh   <= {rs, sh[7:1]};
                  bcnt <= bcnt + 3'd1;
                  if (bcnt == 3'd7) st <= R_STOP;
               end else cnt <= cnt + 16'd1;
            end
            R_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= 16'd0;
                  st  <= R_IDLE;
                  if (rs) begin
                     rdata    <= sh;
                     rx_ready <= 1'b1;
                  end else begin
                     ferr <= 1'b1;
                  end
               end else cnt <= cnt + 16'd1;
            end
            default: st <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, bit time 2*CLK_PER_HALF_BIT clks.
//   clk, rstn : clock, synchronous active-low reset (txd idles high)
//   sdata     : byte to send, sampled when tx_start seen while idle
//   tx_start  : request; tx_busy rises the cycle after it is accepted
//   tx_busy   : high from acceptance until the end of the stop bit
//   txd       : serial output
module uart_tx #(
   parameter int CLK_PER_HALF_BIT = 200
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] sdata,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       txd
);

   localparam logic [15:0] BIT_LAST = 16'(2 * CLK_PER_HALF_BIT - 1);

   logic [8:0]  sh;     // data bits then stop bit, shifted out LSB first
   logic [3:0]  bcnt;
   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         txd     <= 1'b1;
         tx_busy <= 1'b0;
         sh      <= 9'h1ff;
         bcnt    <= 4'd0;
         cnt     <= 16'd0;
      end else if (!tx_busy) begin
         cnt  <= 16'd0;
         bcnt <= 4'd0;
         if (tx_start) begin
            sh      <= {1'b1, sdata};
            txd     <= 1'b0;
            tx_busy <= 1'b1;
         end
      end else if (cnt == BIT_LAST) begin
         cnt <= 16'd0;
         if (bcnt == 4'd9) begin
            tx_busy <= 1'b0;
         end else begin
            txd  <= sh[0];
            sh   <= {1'b1, sh[8:1]};
            bcnt <= bcnt + 4'd1;
         end
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/host_loader.sv
// host_loader: host side of the serial boot protocol.
//   Waits for 0x99, sends length (total_words*4) and the image words, waits
//   for 0xaa, sends the SLD words, then captures OUT_BYTES result bytes.
//   All multi-byte fields go out little-endian.
//   clk, rstn          : clock, synchronous active-low reset
//   rxd / txd          : serial link to the device
//   start              : session start pulse (honoured in IDLE only)
//   total_words        : image words after the length field, latched on start
//   sld_words          : SLD words after 0xaa, latched on start
//   img_addr/img_data  : image memory port, data one cycle after address
//   sld_addr/sld_data  : SLD memory port, data one cycle after address
//   out_valid/out_data : one pulse per captured result byte
//   out_count          : result bytes captured (saturates at OUT_BYTES)
//   busy/done/err      : session status; done and err are sticky
module host_loader
   import host_loader_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 200,
   parameter int OUT_BYTES        = 61440
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rxd,
   output logic        txd,
   input  logic        start,
   input  logic [31:0] total_words,
   input  logic [15:0] sld_words,
   output logic [15:0] img_addr,
   input  logic [31:0] img_data,
   output logic [15:0] sld_addr,
   input  logic [31:0] sld_data,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic [15:0] out_count,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [15:0] OUT_LIM = 16'(OUT_BYTES);

   state_t      state;
   logic [31:0] tw;
   logic [15:0] sw;
   logic [31:0] word;        // word being sent, shifted right per byte
   logic [31:0] wcnt;        // words sent in the current upload phase
   logic [1:0]  bidx;        // byte within word
   logic [1:0]  tph;         // 0: issue, 1: drop go, 2: wait for completion
   logic        fetch_wait;
   logic        rx_seen;
   logic        tx_go, tx_ready, tx_start, tx_busy;
   logic [7:0]  tx_byte, sdata, rdata;
   logic        rx_ready, ferr;
   logic        rx_take, byte_done, word_done;

   // A byte counts once, on the first cycle rx_ready is seen high.
   assign rx_take   = rx_ready & ~rx_seen;
   assign byte_done = (tph == 2'd2) & tx_ready;
   assign word_done = byte_done & (bidx == 2'd3);

   uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
      .clk(clk), .rstn(rstn), .sdata(sdata), .tx_start(tx_start),
      .tx_busy(tx_busy), .txd(txd)
   );

   uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
      .clk(clk), .rstn(rstn), .rxd(rxd), .rdata(rdata),
      .rx_ready(rx_ready), .ferr(ferr)
   );

   host_byte_tx u_btx (
      .clk(clk), .rstn(rstn), .byte_val(tx_byte), .go(tx_go),
      .ready(tx_ready), .sdata(sdata), .tx_start(tx_start), .tx_busy(tx_busy)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= S_IDLE;
         tw         <= 32'd0;
         sw         <= 16'd0;
         word       <= 32'd0;
         wcnt       <= 32'd0;
         bidx       <= 2'd0;
         tph        <= 2'd0;
         fetch_wait <= 1'b0;
         rx_seen    <= 1'b0;
         tx_go      <= 1'b0;
         tx_byte    <= 8'd0;
         img_addr   <= 16'd0;
         sld_addr   <= 16'd0;
         out_valid  <= 1'b0;
         out_data   <= 8'd0;
         out_count  <= 16'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         rx_seen   <= rx_ready;
         out_valid <= 1'b0;

         // Byte sequencer shared by all sending states; walks 'word' LSB first.
         if (state inside {S_SEND_LEN, S_IMG_SEND, S_SLD_SEND}) begin
            case (tph)
               2'd0: if (tx_ready) begin
                  tx_go   <= 1'b1;
                  tx_byte <= word[7:0];
                  tph     <= 2'd1;
               end
               2'd1: begin
                  tx_go <= 1'b0;
                  tph   <= 2'd2;
               end
               default: if (tx_ready) begin
                  word <= word >> 8;
                  bidx <= bidx + 2'd1;
                  tph  <= 2'd0;
               end
            endcase
         end

         case (state)
            S_IDLE: if (start) begin
               tw        <= total_words;
               sw        <= sld_words;
               out_count <= 16'd0;
               img_addr  <= 16'd0;
               sld_addr  <= 16'd0;
               wcnt      <= 32'd0;
               busy      <= 1'b1;
               state     <= S_WAIT_99;
            end
            S_WAIT_99: begin
               if (ferr || (rx_take && rdata != HS_BOOT)) begin
                  state <= S_ERR; busy <= 1'b0; err <= 1'b1;
               end else if (rx_take) begin
                  word  <= tw << 2;
                  bidx  <= 2'd0;
                  tph   <= 2'd0;
                  state <= S_SEND_LEN;
               end
            end
            S_SEND_LEN: if (word_done) begin
               fetch_wait <= 1'b0;
               state      <= (tw == 32'd0) ? S_WAIT_AA : S_IMG_FETCH;
            end
            // Two cycles: address settles, then the memory's data is taken.
            S_IMG_FETCH: begin
               if (!fetch_wait) fetch_wait <= 1'b1;
               else begin
                  word  <= img_data;
                  state <= S_IMG_SEND;
               end
            end
            S_IMG_SEND: if (word_done) begin
               if (wcnt == tw - 32'd1) begin
                  wcnt  <= 32'd0;
                  state <= S_WAIT_AA;
               end else begin
                  wcnt       <= wcnt + 32'd1;
                  img_addr   <= img_addr + 16'd1;
                  fetch_wait <= 1'b0;
                  state      <= S_IMG_FETCH;
               end
            end
            S_WAIT_AA: begin
               if (ferr || (rx_take && rdata != HS_SLD)) begin
                  state <= S_ERR; busy <= 1'b0; err <= 1'b1;
               end else if (rx_take) begin
                  fetch_wait <= 1'b0;
                  state      <= (sw == 16'd0) ? S_RECV : S_SLD_FETCH;
               end
            end
            S_SLD_FETCH: begin
               if (!fetch_wait) fetch_wait <= 1'b1;
               else begin
                  word  <= sld_data;
                  state <= S_SLD_SEND;
               end
            end
            S_SLD_SEND: if (word_done) begin
               if (wcnt == 32'(sw) - 32'd1) begin
                  state <= S_RECV;
               end else begin
                  wcnt       <= wcnt + 32'd1;
                  sld_addr   <= sld_addr + 16'd1;
                  fetch_wait <= 1'b0;
                  state      <= S_SLD_FETCH;
               end
            end
            S_RECV: begin
               if (ferr) begin
                  state <= S_ERR; busy <= 1'b0; err <= 1'b1;
               end else if (rx_take && out_count != OUT_LIM) begin
                  out_valid <= 1'b1;
                  out_data  <= rdata;
                  out_count <= out_count + 16'd1;
                  if (out_count + 16'd1 == OUT_LIM) begin
                     state <= S_DONE; busy <= 1'b0; done <= 1'b1;
                  end
               end
            end
            S_DONE, S_ERR: ;
            default: begin
               state <= S_ERR; busy <= 1'b0; err <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/host_loader.md
HOST_LOADER -- requirements
Module: host_loader

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 200, UART half-bit period in clk cycles, passed to uart_tx/uart_rx.
REQ-002 SHALL have parameter OUT_BYTES, default 61440, number of result bytes captured after SLD upload.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 rxd  input  1  UART serial in, from device txd.
REQ-006 txd  output  1  UART serial out, to device rxd.
REQ-007 start  input  1  one-cycle pulse; begins a session from IDLE only.
REQ-008 total_words  input  32  words sent after length field (program + 0xffffffff terminator + data); sampled on start.
REQ-009 sld_words  input  16  SLD words to send after 0xaa, including both terminators; sampled on start.
REQ-010 img_addr  output  16  word address into image memory; img_data valid exactly 1 cycle later.
REQ-011 img_data  input  32  image word.
REQ-012 sld_addr  output  16  word address into SLD memory; sld_data valid 1 cycle later.
REQ-013 sld_data  input  32  SLD word.
REQ-014 out_valid  output  1  one-cycle pulse per captured result byte.
REQ-015 out_data  output  8  captured result byte, valid with out_valid.
REQ-016 out_count  output  16  result bytes captured this session.
REQ-017 busy  output  1  high in every state except IDLE, DONE, ERR.
REQ-018 done  output  1  high in DONE.
REQ-019 err  output  1  high in ERR.

Function
REQ-020 States: IDLE, WAIT_99, SEND_LEN, IMG_FETCH, IMG_SEND, WAIT_AA, SLD_FETCH, SLD_SEND, RECV, DONE, ERR.
REQ-021 IDLE: start -> WAIT_99; latch total_words, sld_words; clear out_count, address counters; start ignored in all other states.
REQ-022 Byte send: load sdata, assert tx_start 1 cycle... held until tx_busy seen high, then deassert; byte complete when tx_busy returns low.
REQ-023 Byte receive: capture rdata on first cycle rx_ready high; next byte not accepted until rx_ready seen low.
REQ-024 WAIT_99: received byte 0x99 -> SEND_LEN; any other byte or ferr -> ERR.
REQ-025 SEND_LEN: send total_words*4 as 4 bytes, little-endian (bits 7:0 first) -> IMG_FETCH.
REQ-026 IMG_FETCH/IMG_SEND: for img_addr 0..total_words-1, fetch word, send 4 bytes little-endian; after last word -> WAIT_AA; total_words=0 -> WAIT_AA directly after length.
REQ-027 Length field arithmetic: total_words*4 truncated to 32 bits.
REQ-028 WAIT_AA: byte 0xaa -> SLD_FETCH; other byte or ferr -> ERR.
REQ-029 SLD_FETCH/SLD_SEND: for sld_addr 0..sld_words-1, fetch and send 4 bytes little-endian; sld_words=0 -> RECV directly.
REQ-030 RECV: each received byte -> out_valid pulse, out_data=rdata, out_count+1; at out_count==OUT_BYTES -> DONE; ferr -> ERR.
REQ-031 out_count saturates at OUT_BYTES; no wrap.
REQ-032 DONE and ERR sticky; exit only via rstn.
REQ-033 rx byte arriving during SEND_LEN/IMG/SLD phases SHALL be ignored (no ERR, no out_valid).

Reset
REQ-034 On rstn low at a clock edge: state IDLE, tx_start 0, sdata 0, img_addr 0, sld_addr 0, out_valid 0, out_data 0, out_count 0, busy/done/err 0.
REQ-035 Reset mid-session SHALL abort immediately; txd returns idle-high via uart_tx reset; no partial output pulses after reset.

Structure
REQ-036 Shared constants file: HS_BOOT 8'h99, HS_SLD 8'haa, TERM_WORD 32'hffffffff, RESULT_BASE_WORD 4096.
REQ-037 Instantiates existing uart_tx and uart_rx unchanged.
REQ-038 One sub-module host_byte_tx: wraps tx_start/tx_busy handshake, ports byte, go, ready.
REQ-039 Target size 150-300 lines RTL.

Verification
REQ-040 Loopback against device io at CLK_PER_HALF_BIT 8: total_words=4 (2 program, TERM, 1 data) -> device receives length 0x00000010, program in instr memory addr 0,4.
REQ-041 Device sends 0x55 first -> err=1 within 1 cycle after rx capture, busy=0, no tx activity.
REQ-042 sld_words=3 (0x1, TERM, TERM) -> device memory words 2048..2050 = 0x1, 0xffffffff, 0xffffffff, then core_start.
REQ-043 OUT_BYTES=4, device returns 0x01,0x02,0x03,0x04 -> four out_valid pulses in order, out_count=4, done=1.
REQ-044 rstn low during IMG_SEND byte 2 -> next cycle state IDLE, all outputs zero, txd high after uart_tx reset.
REQ-045 start pulsed while busy -> no effect on latched total_words or state.
